// File: rtl/ram_bist.sv
// March-style RAM self-test: write pattern up, read up, write inverse down, read down.
// Drives a 1-cycle synchronous-read RAM and reports mismatch count, first failing address and pass.
module ram_bist #(
  parameter int DEPTH = 256,
  parameter int AWID  = 8,
  parameter int DWID  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DWID-1:0] seed,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AWID+1:0] err_cnt,
  output logic [AWID-1:0] first_err_addr,
  output logic            we,
  output logic [AWID-1:0] addr,
  output logic [DWID-1:0] din,
  input  logic [DWID-1:0] dout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_W0    = 3'd1;
  localparam logic [2:0] S_R1    = 3'd2;
  localparam logic [2:0] S_W1    = 3'd3;
  localparam logic [2:0] S_R2    = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]      state, state_next;
  logic [AWID-1:0] cnt, cnt_next, addr_next;
  logic [DWID-1:0] seed_q, seed_next, pat_next, din_next, pat_cur;
  logic            accept, last;
  logic            cmp_valid, mism;
  logic [DWID-1:0] cmp_exp;
  logic [AWID-1:0] cmp_addr;
  logic [AWID+1:0] err_next;

  assign accept = (state == S_IDLE) && start;
  assign last   = (cnt == AWID'(DEPTH - 1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_W0;
          cnt_next   = '0;
        end
      end
      S_W0, S_R1, S_W1, S_R2: begin
        cnt_next = cnt + AWID'(1);
        if (last) begin
          cnt_next   = '0;
          state_next = state + 3'd1;
        end
      end
      S_DRAIN: state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so addr/din/we line up with the state they belong to.
  assign seed_next = accept ? seed : seed_q;

  always_comb begin
    addr_next = '0;
    case (state_next)
      S_W0, S_R1: addr_next = cnt_next;
      S_W1, S_R2: addr_next = ~cnt_next;
      default:    addr_next = '0;
    endcase
  end

  assign pat_next = seed_next ^ DWID'(addr_next);
  assign pat_cur  = seed_q ^ DWID'(addr);

  always_comb begin
    din_next = '0;
    if (state_next == S_W0) din_next = pat_next;
    else if (state_next == S_W1) din_next = ~pat_next;
  end

  // Read data arrives one cycle after the address, so the expectation is staged one cycle.
  assign mism     = cmp_valid && (dout != cmp_exp);
  assign err_next = err_cnt + {{(AWID+1){1'b0}}, mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      seed_q         <= '0;
      we             <= 1'b0;
      addr           <= '0;
      din            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      cmp_valid      <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      seed_q    <= seed_next;
      we        <= (state_next == S_W0) || (state_next == S_W1);
      addr      <= addr_next;
      din       <= din_next;
      busy      <= (state_next >= S_W0) && (state_next <= S_DRAIN);
      done      <= (state_next == S_DONE);
      cmp_valid <= (state == S_R1) || (state == S_R2);
      cmp_exp   <= (state == S_R1) ? pat_cur : ~pat_cur;
      cmp_addr  <= addr;
      if (accept) begin
        err_cnt        <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
      end else begin
        err_cnt <= err_next;
        if (mism && (err_cnt == '0)) first_err_addr <= cmp_addr;
        if (state == S_DRAIN) pass <= (err_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with injectable read faults and a march-test reference model.
`timescale 1ns/1ps
module tb_ram_bist;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] seed;
  logic        busy, done, pass, we;
  logic [5:0]  err_cnt;
  logic [3:0]  first_err_addr, addr;
  logic [15:0] din, dout;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ram_bist #(.DEPTH(16), .AWID(4), .DWID(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .we(we), .addr(addr), .din(din), .dout(dout)
  );

  // RAM with read-before-write registered output; faults only disturb what is read back.
  logic [15:0] mem [0:15];
  logic [15:0] rd_q;
  logic [3:0]  rd_addr;
  logic        rd_we;
  int          fault_mode = 0;
  logic [3:0]  fault_addr = 4'd5;
  int          fault_bit = 0;

  always @(posedge clk) begin
    if (we) mem[addr] <= din;
    rd_q    <= mem[addr];
    rd_addr <= addr;
    rd_we   <= we;
  end

  always_comb begin
    dout = rd_q;
    if (fault_mode == 2) dout = 16'hFFFF;
    else if (fault_mode == 1 && !rd_we && rd_addr == fault_addr) dout = rd_q & ~(16'h1 << fault_bit);
  end

  function automatic logic [15:0] faulty(input int a, input logic [15:0] v);
    if (fault_mode == 2) return 16'hFFFF;
    if (fault_mode == 1 && a == int'(fault_addr)) return v & ~(16'h1 << fault_bit);
    return v;
  endfunction

  // Algorithm-level model: fill memory, read each word back in march order through the fault.
  function automatic void model_run(input logic [15:0] s, output int errs, output int first);
    logic [15:0] m [16];
    logic [15:0] e;
    errs = 0; first = 0;
    for (int a = 0; a < 16; a++) m[a] = s ^ 16'(a);
    for (int a = 0; a < 16; a++) begin
      e = s ^ 16'(a);
      if (faulty(a, m[a]) !== e) begin if (errs == 0) first = a; errs++; end
    end
    for (int a = 15; a >= 0; a--) m[a] = ~(s ^ 16'(a));
    for (int a = 15; a >= 0; a--) begin
      e = ~(s ^ 16'(a));
      if (faulty(a, m[a]) !== e) begin if (errs == 0) first = a; errs++; end
    end
  endfunction

  int          busy_cycles, done_k, seq_err, bad_k;
  logic [3:0]  addr4;
  logic [15:0] din4;
  logic        we4;

  // Starts one run and records what it observed; the calling test decides what is correct.
  task automatic run_bist(input logic [15:0] s, input bit hold);
    int c;
    logic ew;
    logic [3:0] ea;
    logic [15:0] ed;
    bit chk_din;
    busy_cycles = 0; done_k = 0; seq_err = 0; bad_k = 0;
    for (int w = 0; w < 300 && (busy || done); w++) begin @(posedge clk); #1; end
    start = 1'b1; seed = s;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (busy) busy_cycles++;
      if (k == 4) begin addr4 = addr; din4 = din; we4 = we; end
      if (done) begin done_k = k; break; end
      c = k - 1; chk_din = 0; ew = 1'b0; ea = '0; ed = '0;
      if (c < 16)      begin ew = 1'b1; ea = 4'(c); ed = s ^ 16'(ea); chk_din = 1; end
      else if (c < 32) begin ea = 4'(c - 16); end
      else if (c < 48) begin ew = 1'b1; ea = 4'(15 - (c - 32)); ed = ~(s ^ 16'(ea)); chk_din = 1; end
      else if (c < 64) begin ea = 4'(15 - (c - 48)); end
      if (c < 64) begin
        if (we !== ew || addr !== ea || (chk_din && din !== ed) || busy !== 1'b1) begin
          if (seq_err == 0) bad_k = k;
          seq_err++;
        end
      end else if (c == 64) begin
        if (we !== 1'b0 || busy !== 1'b1) begin if (seq_err == 0) bad_k = k; seq_err++; end
      end
      @(posedge clk); #1;
    end
    $display("[TB] run seed=%h mode=%0d done_k=%0d busy=%0d err_cnt=%0d first=%0d pass=%0b",
             s, fault_mode, done_k, busy_cycles, err_cnt, first_err_addr, pass);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; seed = '0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({we, addr, din, busy, done, pass, err_cnt, first_err_addr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%b addr=%h din=%h busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
               we, addr, din, busy, done, pass, err_cnt, first_err_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_run();
    fault_mode = 0;
    run_bist(16'hA5A5, 1'b0);
    tests_run++; if (done_k !== 66) begin tests_failed++; $display("FAIL clean_done_cycle: got %0d want 66", done_k); end
    tests_run++; if (busy_cycles !== 65) begin tests_failed++; $display("FAIL clean_busy_cycles: got %0d want 65", busy_cycles); end
    tests_run++; if (seq_err !== 0) begin tests_failed++; $display("FAIL clean_bus_sequence: %0d bad cycles, first at %0d, want 0", seq_err, bad_k); end
    tests_run++;
    if (addr4 !== 4'd3 || din4 !== 16'hA5A6 || we4 !== 1'b1) begin
      tests_failed++; $display("FAIL clean_w0_cycle3: got addr=%h din=%h we=%b want 3 a5a6 1", addr4, din4, we4);
    end
    tests_run++;
    if (pass !== 1'b1 || err_cnt !== 6'd0 || first_err_addr !== 4'd0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL clean_result: got pass=%b err=%0d first=%0d busy=%b want 1 0 0 0", pass, err_cnt, first_err_addr, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || pass !== 1'b1 || busy !== 1'b0 || we !== 1'b0 || addr !== 4'd0 || din !== 16'd0) begin
      tests_failed++; $display("FAIL clean_after_done: got done=%b pass=%b busy=%b we=%b addr=%h din=%h want 0 1 0 0 0 0",
                               done, pass, busy, we, addr, din);
    end
  endtask

  task automatic test_single_fault();
    fault_mode = 1; fault_addr = 4'd5; fault_bit = 0;
    run_bist(16'hA5A5, 1'b0);
    tests_run++;
    if (err_cnt !== 6'd1 || first_err_addr !== 4'd5 || pass !== 1'b0 || done_k !== 66) begin
      tests_failed++; $display("FAIL single_fault: got err=%0d first=%0d pass=%b done_k=%0d want 1 5 0 66",
                               err_cnt, first_err_addr, pass, done_k);
    end
    fault_mode = 0;
  endtask

  task automatic test_all_ones();
    fault_mode = 2;
    run_bist(16'h0000, 1'b0);
    tests_run++;
    if (err_cnt !== 6'd31 || first_err_addr !== 4'd0 || pass !== 1'b0 || done_k !== 66) begin
      tests_failed++; $display("FAIL all_ones: got err=%0d first=%0d pass=%b done_k=%0d want 31 0 0 66",
                               err_cnt, first_err_addr, pass, done_k);
    end
    fault_mode = 0;
  endtask

  task automatic test_start_held();
    int k2;
    fault_mode = 0;
    run_bist(16'(($urandom)), 1'b1);
    tests_run++;
    if (done_k !== 66 || busy_cycles !== 65 || seq_err !== 0 || pass !== 1'b1) begin
      tests_failed++; $display("FAIL held_first_run: got done_k=%0d busy=%0d seq_err=%0d pass=%b want 66 65 0 1",
                               done_k, busy_cycles, seq_err, pass);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || pass !== 1'b1 || done !== 1'b0) begin
      tests_failed++; $display("FAIL held_idle_gap: got busy=%b pass=%b done=%b want 0 1 0", busy, pass, done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b1 || pass !== 1'b0 || we !== 1'b1 || addr !== 4'd0) begin
      tests_failed++; $display("FAIL held_restart: got busy=%b pass=%b we=%b addr=%h want 1 0 1 0", busy, pass, we, addr);
    end
    start = 1'b0;
    k2 = 0;
    for (int i = 0; i < 100 && !done; i++) begin @(posedge clk); #1; k2++; end
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b1 || k2 !== 65) begin
      tests_failed++; $display("FAIL held_second_run: got done=%b pass=%b cycles=%0d want 1 1 65", done, pass, k2);
    end
  endtask

  task automatic test_reset_mid_run();
    fault_mode = 2;
    for (int w = 0; w < 300 && (busy || done); w++) begin @(posedge clk); #1; end
    start = 1'b1; seed = 16'(($urandom));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (23) begin @(posedge clk); #1; end
    tests_run++;
    if (addr !== 4'd7 || we !== 1'b0 || busy !== 1'b1 || err_cnt !== 6'd6) begin
      tests_failed++; $display("FAIL midrun_position: got addr=%h we=%b busy=%b err=%0d want 7 0 1 6", addr, we, busy, err_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({we, addr, din, busy, done, pass, err_cnt, first_err_addr} !== '0) begin
      tests_failed++; $display("FAIL midrun_reset: got we=%b addr=%h din=%h busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
                               we, addr, din, busy, done, pass, err_cnt, first_err_addr);
    end
    @(negedge clk);
    fault_mode = 0;
    rst_n = 1'b1;
    run_bist(16'h1234, 1'b0);
    tests_run++;
    if (done_k !== 66 || seq_err !== 0 || pass !== 1'b1 || err_cnt !== 6'd0 || first_err_addr !== 4'd0) begin
      tests_failed++; $display("FAIL after_reset_run: got done_k=%0d seq_err=%0d pass=%b err=%0d first=%0d want 66 0 1 0 0",
                               done_k, seq_err, pass, err_cnt, first_err_addr);
    end
  endtask

  task automatic test_random();
    int errs, first;
    logic [15:0] s;
    for (int i = 0; i < 6; i++) begin
      s = 16'($urandom);
      fault_mode = $urandom_range(0, 2);
      fault_addr = 4'($urandom_range(0, 15));
      fault_bit  = $urandom_range(0, 15);
      model_run(s, errs, first);
      run_bist(s, 1'b0);
      tests_run++;
      if (done_k !== 66 || seq_err !== 0 || int'(err_cnt) !== errs || int'(first_err_addr) !== first ||
          pass !== (errs == 0)) begin
        tests_failed++;
        $display("FAIL random_%0d: seed=%h mode=%0d got done_k=%0d seq_err=%0d err=%0d first=%0d pass=%b want 66 0 %0d %0d %0b",
                 i, s, fault_mode, done_k, seq_err, err_cnt, first_err_addr, pass, errs, first, errs == 0);
      end
    end
    fault_mode = 0;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_fault();
    test_all_ones();
    test_start_held();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Parameters
REQ-001 The block SHALL provide parameter DEPTH, default 256: number of RAM words tested; DEPTH = 2**AWID.
REQ-002 The block SHALL provide parameter AWID, default 8: address width.
REQ-003 The block SHALL provide parameter DWID, default 16: data width; DWID >= AWID is required.

Interface
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-005 The block SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have start  input  1  run request; sampled only in IDLE.
REQ-007 The block SHALL have seed  input  DWID  pattern seed; sampled with start.
REQ-008 The block SHALL have busy  output  1  run in progress.
REQ-009 The block SHALL have done  output  1  one-cycle end-of-run pulse.
REQ-010 The block SHALL have pass  output  1  run result; valid from done, held until the next accepted start.
REQ-011 The block SHALL have err_cnt  output  AWID+2  mismatch count for the run.
REQ-012 The block SHALL have first_err_addr  output  AWID  address of the first mismatch; 0 if no mismatch.
REQ-013 The block SHALL have we, addr, din  outputs  1/AWID/DWID  RAM controller-side signals, registered.
REQ-014 The block SHALL have dout  input  DWID  RAM read data; dout reflects the address registered on the previous edge (1-cycle synchronous read).

Function
REQ-015 The pattern SHALL be D(a) = seed_q XOR zero-extended a, where seed_q is seed captured at start.
REQ-016 The FSM SHALL have states IDLE, W0, R1, W1, R2, DRAIN, DONE.
REQ-017 IDLE->W0 SHALL occur on an edge where start=1; start is ignored in every other state.
REQ-018 W0 SHALL last DEPTH cycles, addr ascending 0..DEPTH-1, we=1, din=D(addr).
REQ-019 R1 SHALL last DEPTH cycles, addr ascending, we=0; dout in the following cycle is compared against D(a).
REQ-020 W1 SHALL last DEPTH cycles, addr descending DEPTH-1..0, we=1, din=~D(addr).
REQ-021 R2 SHALL last DEPTH cycles, addr descending, we=0; dout in the following cycle is compared against ~D(a).
REQ-022 The compare SHALL be a 1-stage pipeline independent of state; the final R1 compare occurs in the first W1 cycle, and the final R2 compare occurs in DRAIN.
REQ-023 DRAIN SHALL last 1 cycle with we=0; DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-024 busy SHALL be 1 in W0 through DRAIN, which is 4*DEPTH+1 cycles starting at the start-sampling edge.
REQ-025 Each mismatch SHALL increment err_cnt; the width is sized for a maximum of 2*DEPTH mismatches, so no wrap can occur.
REQ-026 The first mismatch of a run SHALL load first_err_addr; later mismatches SHALL leave it unchanged.
REQ-027 pass SHALL be set in DONE to (err_cnt==0), including the DRAIN compare.
REQ-028 An accepted start SHALL clear err_cnt, first_err_addr and pass.
REQ-029 In IDLE and DONE, we SHALL be 0; addr and din SHALL hold 0.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force state IDLE and we=0, addr=0, din=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, in any state including mid-run.
REQ-031 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification (DEPTH=16, AWID=4, DWID=16; bench RAM registers dout on the same edge it samples addr/we)
REQ-032 Reset: assert rst_n=0 mid-clock -> all outputs read 0 before the next edge.
REQ-033 Clean run: seed=0xA5A5, start pulse -> W0 cycle 3 shows addr=3, din=0xA5A6, we=1; busy is high 65 cycles; done is high cycle 66; pass=1; err_cnt=0.
REQ-034 Single fault: bench corrupts dout bit0 to 0 only when reading addr 5 -> R1 matches (D(5)=0xA5A0), R2 mismatches (0x5A5F) -> err_cnt=1, first_err_addr=5, pass=0.
REQ-035 All-ones fault: seed=0, dout forced 0xFFFF -> R1 errors 16, R2 errors 15 (addr 0 matches) -> err_cnt=31, first_err_addr=0, pass=0.
REQ-036 Start held high continuously -> no restart while busy; a new run begins on the edge after the done cycle (IDLE); pass from the prior run clears at that edge.
REQ-037 Reset during R1 (addr=7), then a new start with seed=0x1234 on a fault-free RAM -> clean run, pass=1, err_cnt=0, no residue from the aborted run.
